key_matrix_scan: RTL and testbench
==================================

// Module: key_matrix_scan
// PURPOSE
//  Input-side counterpart of the LED matrix driver: strobes the columns of a switch/button
//  matrix, samples the row sense lines, debounces every key and emits press/release
//  events over a valid/ready stream. Runs in the low-speed fabric clock domain next to the
//  matrix/auto-off logic; events feed the control FSM (wake, mode change, power-off).
// PARAMETERS
//  N_COL     4  number of column strobe outputs
//  N_ROW     3  number of row sense inputs
//  SETTLE    4  cycles a column is driven before rows are latched; must be >= 3 (2FF sync)
//  DEBOUNCE  3  consecutive scans a key must disagree with its stable state before flipping
// PORTS
//  clk          in   1              single clock
//  rst          in   1              synchronous, active-high reset
//  col_o        out  N_COL          one-hot column strobe, active high
//  row_i        in   N_ROW          raw row sense, active high, asynchronous to clk
//  evt_valid    out  1              event available
//  evt_ready    in   1              consumer accepts event when valid&ready at posedge
//  evt_key      out  clog2(N_COL*N_ROW)  key index = col*N_ROW + row
//  evt_press    out  1              1 = press, 0 = release
//  key_state    out  N_COL*N_ROW    debounced state of every key
// BEHAVIOUR
//  - Reset: col_o=0, evt_valid=0, evt_key=0, evt_press=0, key_state=0, all debounce
//    counters 0, column index 0, FSM in DRIVE with settle counter 0. Reset mid-operation
//    (incl. stalled) discards any pending event; outputs at reset values the next cycle.
//  - row_i passes a 2-FF synchronizer before use.
//  - FSM per column c (col_o = 1<<c throughout DRIVE, LATCH and CHECK):
//    DRIVE: SETTLE cycles; LATCH: 1 cycle, capture synchronized rows into sample[];
//    CHECK: row r = 0..N_ROW-1, one row per cycle unless stalled; after last row, c wraps
//    N_COL-1 -> 0 and FSM returns to DRIVE. Unstalled column slot = SETTLE+1+N_ROW cycles.
//  - CHECK of key k (c*N_ROW+r): sample[r]==key_state[k] -> cnt[k]<=0;
//    else cnt[k]==DEBOUNCE-1 -> event required; else cnt[k]<=cnt[k]+1.
//  - Event required and slot free: key_state[k] flips, cnt[k]<=0, event loaded
//    (evt_valid=1 next cycle, evt_key=k, evt_press=new state), FSM advances.
//  - Event required and slot full: stall -- FSM, counters, key_state, col_o all hold;
//    retry each cycle. No event is ever dropped or reordered.
//  - Slot freed by valid&ready; a load in the same cycle as the pop is allowed (no bubble).
//  - evt_key/evt_press stable while evt_valid=1 and not accepted.
//  - Keys changing in the same column are reported in ascending row order.
// CONFIGURATION
//  KEY_SCAN_FIFO_EN defined: events go through a 4-entry FIFO; slot full = FIFO holds 4;
//    evt_* presents the FIFO head; scanning stalls only when 4 events are queued.
//  KEY_SCAN_FIFO_EN undefined: single holding register; slot full = evt_valid=1.
// TESTING  (N_COL=4, N_ROW=3, SETTLE=4, DEBOUNCE=3; scan period 32 cycles)
//  - Idle, row_i=0, evt_ready=1 -> col_o 0001 for 8 cycles, 0010, 0100, 1000, wraps to
//    0001 at cycle 32; evt_valid never 1.
//  - Hold row_i[2] high whenever col_o=0010 -> evt_valid with evt_key=5, evt_press=1
//    during the 3rd col1 scan; key_state[5]=1; releasing likewise -> evt_key=5, press=0.
//  - Row asserted for only 2 col1 scans then released -> no event, key_state stays 0.
//  - evt_ready=0, press keys 0 and 1 together -> one event key=0 held, col_o stuck at 0001;
//    raise evt_ready -> key=0 accepted, then key=1 event, scanning resumes.
//  - Assert rst during a stall -> next cycle col_o=0, evt_valid=0, key_state=0; scan
//    restarts at column 0.
//  - With KEY_SCAN_FIFO_EN, evt_ready=0, press keys 0,1,2,3,4 -> 4 events queued, stall
//    on key 4; drain -> keys 0..4 in order, each press=1.

Source files
------------

// File: rtl/key_matrix_scan.sv
// key_matrix_scan: strobes a key matrix column by column, debounces every key and streams press/release events (define KEY_SCAN_FIFO_EN for a 4-entry event FIFO)
module key_matrix_scan #(
    parameter int N_COL    = 4,
    parameter int N_ROW    = 3,
    parameter int SETTLE   = 4,
    parameter int DEBOUNCE = 3,
    localparam int N_KEY   = N_COL * N_ROW,
    localparam int KW      = (N_KEY > 1) ? $clog2(N_KEY) : 1
) (
    input  logic             clk,
    input  logic             rst,
    output logic [N_COL-1:0] col_o,
    input  logic [N_ROW-1:0] row_i,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [KW-1:0]    evt_key,
    output logic             evt_press,
    output logic [N_KEY-1:0] key_state
);
    localparam int CW = (N_COL > 1) ? $clog2(N_COL) : 1;
    localparam int RW = (N_ROW > 1) ? $clog2(N_ROW) : 1;
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    typedef enum logic [1:0] {DRIVE, LATCH, CHECK} state_t;

    state_t           state_q, state_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic [CW-1:0]    col_idx_q, col_idx_d;
    logic [RW-1:0]    row_idx_q, row_idx_d;
    logic [N_COL-1:0] col_q, col_d;
    logic [N_ROW-1:0] sync1_q, sync1_d, sync2_q, sync2_d, sample_q, sample_d;
    logic [N_KEY-1:0] key_state_q, key_state_d;
    logic [DW-1:0]    cnt_q [N_KEY];
    logic [DW-1:0]    cnt_d [N_KEY];
    logic [KW-1:0]    key_k;
    logic             slot_full, load, advance, pop;

    assign key_k = KW'(col_idx_q) * KW'(N_ROW) + KW'(row_idx_q);

    // scan FSM, debounce counters and event requests; a blocked event freezes the whole scan
    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        col_idx_d   = col_idx_q;
        row_idx_d   = row_idx_q;
        sample_d    = sample_q;
        key_state_d = key_state_q;
        cnt_d       = cnt_q;
        sync1_d     = row_i;
        sync2_d     = sync1_q;
        load        = 1'b0;
        advance     = 1'b0;
        case (state_q)
            DRIVE: begin
                settle_d = (settle_q == SW'(SETTLE - 1)) ? '0 : settle_q + 1'b1;
                state_d  = (settle_q == SW'(SETTLE - 1)) ? LATCH : DRIVE;
            end
            LATCH: begin
                sample_d = sync2_q;
                state_d  = CHECK;
            end
            CHECK: begin
                if (sample_q[row_idx_q] == key_state_q[key_k]) begin
                    cnt_d[key_k] = '0;
                    advance      = 1'b1;
                end else if (cnt_q[key_k] == DW'(DEBOUNCE - 1)) begin
                    if (!slot_full) begin
                        key_state_d[key_k] = ~key_state_q[key_k];
                        cnt_d[key_k]       = '0;
                        load               = 1'b1;
                        advance            = 1'b1;
                    end
                end else begin
                    cnt_d[key_k] = cnt_q[key_k] + 1'b1;
                    advance      = 1'b1;
                end
                if (advance) begin
                    if (row_idx_q == RW'(N_ROW - 1)) begin
                        row_idx_d = '0;
                        state_d   = DRIVE;
                        col_idx_d = (col_idx_q == CW'(N_COL - 1)) ? '0 : col_idx_q + 1'b1;
                    end else begin
                        row_idx_d = row_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = DRIVE;
        endcase
        col_d = N_COL'(1) << col_idx_d;
    end

    // scan state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= DRIVE;
            settle_q    <= '0;
            col_idx_q   <= '0;
            row_idx_q   <= '0;
            col_q       <= '0;
            sync1_q     <= '0;
            sync2_q     <= '0;
            sample_q    <= '0;
            key_state_q <= '0;
            cnt_q       <= '{default: '0};
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            col_idx_q   <= col_idx_d;
            row_idx_q   <= row_idx_d;
            col_q       <= col_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            sample_q    <= sample_d;
            key_state_q <= key_state_d;
            cnt_q       <= cnt_d;
        end
    end

    assign col_o     = col_q;
    assign key_state = key_state_q;

`ifdef KEY_SCAN_FIFO_EN
    logic [KW-1:0] fifo_key_q [4];
    logic [KW-1:0] fifo_key_d [4];
    logic [3:0]    fifo_press_q, fifo_press_d;
    logic [1:0]    rd_q, rd_d, wr_q, wr_d;
    logic [2:0]    fill_q, fill_d;

    assign pop       = (fill_q != 3'd0) & evt_ready;
    assign slot_full = (fill_q == 3'd4) & ~evt_ready;

    // event FIFO: push and pop may happen in the same cycle, even when full
    always_comb begin
        fifo_key_d   = fifo_key_q;
        fifo_press_d = fifo_press_q;
        if (load) begin
            fifo_key_d[wr_q]   = key_k;
            fifo_press_d[wr_q] = ~key_state_q[key_k];
        end
        wr_d   = wr_q + 2'(load);
        rd_d   = rd_q + 2'(pop);
        fill_d = fill_q + 3'(load) - 3'(pop);
    end

    // event FIFO registers
    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_key_q   <= '{default: '0};
            fifo_press_q <= '0;
            rd_q         <= '0;
            wr_q         <= '0;
            fill_q       <= '0;
        end else begin
            fifo_key_q   <= fifo_key_d;
            fifo_press_q <= fifo_press_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            fill_q       <= fill_d;
        end
    end

    assign evt_valid = fill_q != 3'd0;
    assign evt_key   = fifo_key_q[rd_q];
    assign evt_press = fifo_press_q[rd_q];
`else
    logic          evt_valid_q, evt_valid_d, evt_press_q, evt_press_d;
    logic [KW-1:0] evt_key_q, evt_key_d;

    assign pop       = evt_valid_q & evt_ready;
    assign slot_full = evt_valid_q & ~evt_ready;

    // single holding register: a new event may replace the one accepted this cycle
    always_comb begin
        evt_valid_d = load | (evt_valid_q & ~pop);
        evt_key_d   = load ? key_k : evt_key_q;
        evt_press_d = load ? ~key_state_q[key_k] : evt_press_q;
    end

    // holding register
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_valid_q <= 1'b0;
            evt_key_q   <= '0;
            evt_press_q <= 1'b0;
        end else begin
            evt_valid_q <= evt_valid_d;
            evt_key_q   <= evt_key_d;
            evt_press_q <= evt_press_d;
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_key   = evt_key_q;
    assign evt_press = evt_press_q;
`endif
endmodule

// File: tb/tb_key_matrix_scan.sv
// tb_key_matrix_scan: randomized key matrix with frame-level debounce model and event scoreboard
module tb_key_matrix_scan;
    localparam int NC = 4, NR = 3, NK = 12, DEB = 3;
`ifdef KEY_SCAN_FIFO_EN
    localparam logic [11:0] STALL_KEYS = 12'h01F;
    localparam logic [3:0]  STALL_COL  = 4'b0010;
`else
    localparam logic [11:0] STALL_KEYS = 12'h003;
    localparam logic [3:0]  STALL_COL  = 4'b0001;
`endif

    typedef struct packed {logic [3:0] key; logic press;} ev_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [3:0]    col_o;
    logic [2:0]    row_i;
    logic          evt_valid;
    logic          evt_ready = 1'b1;
    logic [3:0]    evt_key;
    logic          evt_press;
    logic [11:0]   key_state;

    logic [11:0]   next_pressed = '0;
    logic [11:0]   pressed = '0;
    logic [11:0]   stable = '0;
    int            cnt [NK];
    ev_t           q [$];
    logic [3:0]    prev_col = '0;
    int            frame_cnt = 0;
    logic          rand_rdy = 1'b0;
    logic          force_rdy = 1'b1;
    logic          hold_pend = 1'b0;
    logic [3:0]    hold_key;
    logic          hold_press;
    int            vectors = 0;
    int            errs = 0;

    key_matrix_scan #(.N_COL(NC), .N_ROW(NR), .SETTLE(4), .DEBOUNCE(DEB)) dut (
        .clk(clk), .rst(rst), .col_o(col_o), .row_i(row_i), .evt_valid(evt_valid),
        .evt_ready(evt_ready), .evt_key(evt_key), .evt_press(evt_press), .key_state(key_state)
    );

    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // physical matrix: a pressed key connects its column strobe to its row line
    always_comb begin
        row_i = '0;
        for (int c = 0; c < NC; c++)
            for (int r = 0; r < NR; r++)
                if (col_o[c] && pressed[c*NR+r]) row_i[r] = 1'b1;
    end

    // ready driver
    initial forever begin
        @(posedge clk);
        #2;
        evt_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : force_rdy;
    end

    // frame model: the key pattern is fixed per full scan; each scan applies the debounce rule in key order
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            stable = '0;
            for (int k = 0; k < NK; k++) cnt[k] = 0;
            prev_col = '0;
        end else begin
            if (col_o == 4'b0001 && prev_col != 4'b0001) begin
                chk("frame_key_state", 32'(key_state), 32'(stable));
                pressed = next_pressed;
                for (int k = 0; k < NK; k++) begin
                    if (pressed[k] == stable[k]) cnt[k] = 0;
                    else if (cnt[k] == DEB - 1) begin
                        ev_t e;
                        stable[k] = ~stable[k];
                        cnt[k] = 0;
                        e.key = 4'(k);
                        e.press = stable[k];
                        q.push_back(e);
                    end else cnt[k]++;
                end
                frame_cnt++;
            end
            prev_col = col_o;
        end
    end

    // monitor: pops an expected event on every handshake, checks held events stay put
    always @(negedge clk) begin
        if (rst) hold_pend = 1'b0;
        else begin
            if (hold_pend) begin
                chk("hold_valid", 32'(evt_valid), 32'd1);
                chk("hold_key", 32'(evt_key), 32'(hold_key));
                chk("hold_press", 32'(evt_press), 32'(hold_press));
            end
            if (evt_valid && evt_ready) begin
                if (q.size() == 0) begin
                    vectors++;
                    errs++;
                    $display("FAIL unexpected_event: got key %0d press %0d, expected none", evt_key, evt_press);
                end else begin
                    ev_t e;
                    e = q.pop_front();
                    chk("evt_key", 32'(evt_key), 32'(e.key));
                    chk("evt_press", 32'(evt_press), 32'(e.press));
                end
            end
            hold_pend = evt_valid && !evt_ready;
            hold_key = evt_key;
            hold_press = evt_press;
        end
    end

    task automatic wait_frames(input int n);
        int tgt = frame_cnt + n;
        int budget = 0;
        while (frame_cnt < tgt && budget < 80 * n + 400) begin
            @(posedge clk);
            #2;
            budget++;
        end
        if (frame_cnt < tgt) begin
            vectors++;
            errs++;
            $display("FAIL frame_timeout: got %0d frames, expected %0d", frame_cnt, tgt);
        end
    endtask

    task automatic wait_valid(input int n);
        int budget = 0;
        while (!evt_valid && budget < n) begin
            @(negedge clk);
            budget++;
        end
        chk("wait_valid", 32'(evt_valid), 32'd1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_col", 32'(col_o), 32'd0);
        chk("rst_valid", 32'(evt_valid), 32'd0);
        chk("rst_key", 32'(evt_key), 32'd0);
        chk("rst_press", 32'(evt_press), 32'd0);
        chk("rst_state", 32'(key_state), 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        for (int t = 0; t <= 40; t++) begin
            @(negedge clk);
            chk("idle_col", 32'(col_o), (t == 0) ? 32'd0 : 32'd1 << ((t / 8) % 4));
            chk("idle_valid", 32'(evt_valid), 32'd0);
        end
        next_pressed = 12'h020;
        wait_frames(4);
        next_pressed = 12'h000;
        wait_frames(4);
        next_pressed = 12'h020;
        wait_frames(2);
        next_pressed = 12'h000;
        wait_frames(3);
        force_rdy = 1'b0;
        next_pressed = STALL_KEYS;
        wait_valid(400);
        repeat (40) @(negedge clk);
        chk("stall_col", 32'(col_o), 32'(STALL_COL));
        chk("stall_head_key", 32'(evt_key), 32'd0);
        chk("stall_head_press", 32'(evt_press), 32'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("midrst_col", 32'(col_o), 32'd0);
        chk("midrst_valid", 32'(evt_valid), 32'd0);
        chk("midrst_state", 32'(key_state), 32'd0);
        wait_valid(400);
        repeat (40) @(negedge clk);
        chk("stall2_col", 32'(col_o), 32'(STALL_COL));
        force_rdy = 1'b1;
        wait_frames(3);
        chk("stall_drained", 32'(q.size()), 32'd0);
        next_pressed = 12'h000;
        wait_frames(4);
        rand_rdy = 1'b1;
        for (int i = 0; i < 30; i++) begin
            next_pressed = 12'($urandom & $urandom);
            wait_frames($urandom_range(1, 4));
        end
        rand_rdy = 1'b0;
        force_rdy = 1'b1;
        next_pressed = 12'h000;
        wait_frames(5);
        repeat (10) @(negedge clk);
        chk("final_queue_empty", 32'(q.size()), 32'd0);
        chk("final_state", 32'(key_state), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
